mac_tx_arbiter: RTL and testbench

Frame-atomic 2:1 arbiter that shares the single tri-mode MAC transmit AXI-Stream port between the scheduled (time-aware) channel and the legacy channel. It sits in the MAC clock domain, between the two transmit client FIFOs and the MAC core `tx_axis_mac_*` input. Channel choice is made only at frame boundaries: scheduled traffic has strict priority, and each channel is qualified by a gate signal from the shaper. Frames longer than the configured limit are truncated with an error marker, and their tails are discarded.

---
 rtl/mac_tx_pkg.sv | 17 +
 rtl/frame_cnt.sv | 27 ++
 rtl/mac_tx_arbiter.sv | 151 +++++++++++++++
 tb/tb_mac_tx_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_tx_pkg.sv
// Shared types and constants for the MAC transmit arbiter.
// State encoding, channel ids and the default frame length limit.
package mac_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCHED  = 2'd1,
    ST_LEGACY = 2'd2,
    ST_DROP   = 2'd3
  } arb_state_e;

  localparam logic CH_SCHED  = 1'b0;
  localparam logic CH_LEGACY = 1'b1;

  localparam int DEFAULT_MAX_FRAME_BYTES = 1522;

endpackage

// File: rtl/frame_cnt.sv
// Wrapping event counter with enable, used for the per-channel and truncation
// frame statistics.
module frame_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mac_tx_arbiter.sv
// Frame-atomic 2:1 arbiter onto the MAC transmit stream: scheduled channel has
// strict priority at frame boundaries, oversize frames are cut and drained.
module mac_tx_arbiter
  import mac_tx_pkg::*;
#(
  parameter int MAX_FRAME_BYTES = DEFAULT_MAX_FRAME_BYTES,
  parameter int CNT_W           = 16
) (
  input  logic             tx_mac_aclk,
  input  logic             tx_mac_resetn,
  input  logic             sched_gate,
  input  logic             legacy_gate,
  input  logic [7:0]       s_sched_tdata,
  input  logic             s_sched_tvalid,
  input  logic             s_sched_tlast,
  output logic             s_sched_tready,
  input  logic [7:0]       s_legacy_tdata,
  input  logic             s_legacy_tvalid,
  input  logic             s_legacy_tlast,
  output logic             s_legacy_tready,
  output logic [7:0]       m_tdata,
  output logic             m_tvalid,
  output logic             m_tlast,
  output logic             m_tuser,
  input  logic             m_tready,
  output logic             busy,
  output logic [CNT_W-1:0] sched_frames,
  output logic [CNT_W-1:0] legacy_frames,
  output logic [CNT_W-1:0] trunc_frames
);

  localparam int BCNT_W = $clog2(MAX_FRAME_BYTES + 1);
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(MAX_FRAME_BYTES - 1);

  arb_state_e        state_q, state_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              drop_ch_q, drop_ch_d;

  logic              gnt_legacy;
  logic              in_valid;
  logic              in_last;
  logic [7:0]        in_data;
  logic              at_limit;
  logic              accept;
  logic              sched_done;
  logic              legacy_done;
  logic              trunc_done;

  // Granted source; only meaningful in SCHED/LEGACY.
  always_comb begin
    gnt_legacy = (state_q == ST_LEGACY);
    in_valid   = gnt_legacy ? s_legacy_tvalid : s_sched_tvalid;
    in_last    = gnt_legacy ? s_legacy_tlast  : s_sched_tlast;
    in_data    = gnt_legacy ? s_legacy_tdata  : s_sched_tdata;
    at_limit   = (bcnt_q == LAST_BEAT);
    accept     = in_valid && m_tready;
  end

  always_comb begin
    state_d         = state_q;
    bcnt_d          = bcnt_q;
    drop_ch_d       = drop_ch_q;
    m_tdata         = '0;
    m_tvalid        = 1'b0;
    m_tlast         = 1'b0;
    m_tuser         = 1'b0;
    s_sched_tready  = 1'b0;
    s_legacy_tready = 1'b0;
    sched_done      = 1'b0;
    legacy_done     = 1'b0;
    trunc_done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bcnt_d = '0;
        if (s_sched_tvalid && sched_gate)        state_d = ST_SCHED;
        else if (s_legacy_tvalid && legacy_gate) state_d = ST_LEGACY;
      end

      ST_SCHED, ST_LEGACY: begin
        m_tvalid        = in_valid;
        m_tdata         = in_data;
        m_tlast         = in_valid && (in_last || at_limit);
        m_tuser         = in_valid && at_limit && !in_last;
        s_sched_tready  = !gnt_legacy && m_tready;
        s_legacy_tready = gnt_legacy && m_tready;
        if (accept) begin
          bcnt_d = bcnt_q + BCNT_W'(1);
          // A frame that hits the limit without its own tlast is cut here.
          if (at_limit && !in_last) begin
            state_d    = ST_DROP;
            drop_ch_d  = gnt_legacy ? CH_LEGACY : CH_SCHED;
            trunc_done = 1'b1;
          end else if (in_last) begin
            state_d     = ST_IDLE;
            sched_done  = !gnt_legacy;
            legacy_done = gnt_legacy;
          end
        end
      end

      ST_DROP: begin
        s_sched_tready  = (drop_ch_q == CH_SCHED);
        s_legacy_tready = (drop_ch_q == CH_LEGACY);
        if (drop_ch_q == CH_LEGACY) begin
          if (s_legacy_tvalid && s_legacy_tlast) state_d = ST_IDLE;
        end else begin
          if (s_sched_tvalid && s_sched_tlast) state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge tx_mac_aclk or negedge tx_mac_resetn) begin
    if (!tx_mac_resetn) begin
      state_q   <= ST_IDLE;
      bcnt_q    <= '0;
      drop_ch_q <= CH_SCHED;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      drop_ch_q <= drop_ch_d;
    end
  end

  assign busy = (state_q != ST_IDLE);

  frame_cnt #(.CNT_W(CNT_W)) u_sched_cnt (
    .clk   (tx_mac_aclk),
    .rst_n (tx_mac_resetn),
    .en    (sched_done),
    .cnt   (sched_frames)
  );

  frame_cnt #(.CNT_W(CNT_W)) u_legacy_cnt (
    .clk   (tx_mac_aclk),
    .rst_n (tx_mac_resetn),
    .en    (legacy_done),
    .cnt   (legacy_frames)
  );

  frame_cnt #(.CNT_W(CNT_W)) u_trunc_cnt (
    .clk   (tx_mac_aclk),
    .rst_n (tx_mac_resetn),
    .en    (trunc_done),
    .cnt   (trunc_frames)
  );

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Bench for mac_tx_arbiter: queue-based sources and a frame-level reference
// model of the expected MAC output stream and statistics.
module tb_mac_tx_arbiter;

  localparam int MAXB  = 100;
  localparam int CNT_W = 16;

  logic             tx_mac_aclk = 1'b0;
  logic             tx_mac_resetn;
  logic             sched_gate, legacy_gate;
  logic [7:0]       s_sched_tdata, s_legacy_tdata;
  logic             s_sched_tvalid, s_sched_tlast, s_sched_tready;
  logic             s_legacy_tvalid, s_legacy_tlast, s_legacy_tready;
  logic [7:0]       m_tdata;
  logic             m_tvalid, m_tlast, m_tuser, m_tready;
  logic             busy;
  logic [CNT_W-1:0] sched_frames, legacy_frames, trunc_frames;

  always #5 tx_mac_aclk = ~tx_mac_aclk;

  mac_tx_arbiter #(.MAX_FRAME_BYTES(MAXB), .CNT_W(CNT_W)) dut (
    .tx_mac_aclk     (tx_mac_aclk),
    .tx_mac_resetn   (tx_mac_resetn),
    .sched_gate      (sched_gate),
    .legacy_gate     (legacy_gate),
    .s_sched_tdata   (s_sched_tdata),
    .s_sched_tvalid  (s_sched_tvalid),
    .s_sched_tlast   (s_sched_tlast),
    .s_sched_tready  (s_sched_tready),
    .s_legacy_tdata  (s_legacy_tdata),
    .s_legacy_tvalid (s_legacy_tvalid),
    .s_legacy_tlast  (s_legacy_tlast),
    .s_legacy_tready (s_legacy_tready),
    .m_tdata         (m_tdata),
    .m_tvalid        (m_tvalid),
    .m_tlast         (m_tlast),
    .m_tuser         (m_tuser),
    .m_tready        (m_tready),
    .busy            (busy),
    .sched_frames    (sched_frames),
    .legacy_frames   (legacy_frames),
    .trunc_frames    (trunc_frames)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  beat_t sq[$];
  beat_t lq[$];
  beat_t expq[$];
  beat_t obs_b[$];
  int    obs_c[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_s  = 0;
  int exp_l  = 0;
  int exp_t  = 0;
  int leg_popped = 0;
  int start_cyc;
  bit pred_s = 1'b0;
  bit pred_l = 1'b0;
  bit rnd_ready = 1'b0;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Reference model: a frame of len beats leaves as its first MAXB beats,
  // the MAXB-th carrying tlast and tuser when the frame is longer than MAXB.
  task automatic gen_frame(input bit ch, input int len);
    beat_t b, e;
    for (int i = 0; i < len; i++) begin
      b.d = 8'($urandom);
      b.l = (i == len - 1);
      b.u = 1'b0;
      if (ch) lq.push_back(b);
      else    sq.push_back(b);
      if (i < MAXB) begin
        e   = b;
        e.l = b.l || (i == MAXB - 1);
        e.u = (i == MAXB - 1) && (len > MAXB);
        expq.push_back(e);
      end
    end
    if (len > MAXB) exp_t++;
    else if (ch)    exp_l++;
    else            exp_s++;
  endtask

  task automatic step();
    @(negedge tx_mac_aclk);
    if (pred_s) void'(sq.pop_front());
    if (pred_l) begin
      void'(lq.pop_front());
      leg_popped++;
    end
    m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    s_sched_tvalid  = (sq.size() > 0);
    s_sched_tdata   = (sq.size() > 0) ? sq[0].d : 8'h00;
    s_sched_tlast   = (sq.size() > 0) ? sq[0].l : 1'b0;
    s_legacy_tvalid = (lq.size() > 0);
    s_legacy_tdata  = (lq.size() > 0) ? lq[0].d : 8'h00;
    s_legacy_tlast  = (lq.size() > 0) ? lq[0].l : 1'b0;
    #1;
    pred_s = s_sched_tvalid && s_sched_tready;
    pred_l = s_legacy_tvalid && s_legacy_tready;
    if (m_tvalid) begin
      chk("rdy_mirror", {62'd0, s_sched_tready | s_legacy_tready, s_sched_tready & s_legacy_tready},
          {62'd0, m_tready, 1'b0});
      if (m_tready) begin
        obs_b.push_back({m_tdata, m_tlast, m_tuser});
        obs_c.push_back(cyc);
        chk("src_one_hs", 64'(int'(pred_s) + int'(pred_l)), 64'd1);
      end
    end else begin
      chk("ctl_novalid", {62'd0, m_tlast, m_tuser}, 64'd0);
    end
    cyc++;
  endtask

  task automatic run_until(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(sq.size() == 0 && lq.size() == 0 && !busy && !pred_s && !pred_l) && n < budget);
    chk({tag, "_done"}, 64'(n < budget), 64'd1);
  endtask

  task automatic check_stream(input string tag);
    int bad;
    int n;
    chk({tag, "_len"}, 64'(obs_b.size()), 64'(expq.size()));
    n   = (obs_b.size() < expq.size()) ? obs_b.size() : expq.size();
    bad = n - 1;
    for (int i = 0; i < n; i++) begin
      if (obs_b[i] !== expq[i]) begin
        bad = i;
        break;
      end
    end
    if (n > 0) chk({tag, "_beats"}, {54'd0, obs_b[bad]}, {54'd0, expq[bad]});
    chk({tag, "_cnt"}, {16'd0, sched_frames, legacy_frames, trunc_frames},
        {16'd0, 16'(exp_s), 16'(exp_l), 16'(exp_t)});
    obs_b.delete();
    obs_c.delete();
    expq.delete();
  endtask

  initial begin
    tx_mac_resetn   = 1'b0;
    sched_gate      = 1'b0;
    legacy_gate     = 1'b0;
    s_sched_tvalid  = 1'b0;
    s_sched_tdata   = 8'h00;
    s_sched_tlast   = 1'b0;
    s_legacy_tvalid = 1'b0;
    s_legacy_tdata  = 8'h00;
    s_legacy_tlast  = 1'b0;
    m_tready        = 1'b1;
    repeat (2) @(negedge tx_mac_aclk);
    #1;
    chk("reset_outs", {54'd0, m_tvalid, m_tlast, m_tuser, busy, s_sched_tready, s_legacy_tready, m_tdata},
        64'd0);
    chk("reset_cnt", {16'd0, sched_frames, legacy_frames, trunc_frames}, 64'd0);
    @(negedge tx_mac_aclk);
    tx_mac_resetn = 1'b1;

    // Single legacy frame.
    legacy_gate = 1'b1;
    start_cyc = cyc;
    gen_frame(1'b1, 64);
    run_until("leg64", 300);
    chk("leg64_latency", 64'(obs_c[0] - start_cyc), 64'd1);
    check_stream("leg64");

    // Contention: scheduled first, one idle cycle, then legacy.
    sched_gate = 1'b1;
    start_cyc = cyc;
    gen_frame(1'b0, 20);
    gen_frame(1'b1, 30);
    run_until("contend", 300);
    chk("contend_latency", 64'(obs_c[0] - start_cyc), 64'd1);
    chk("contend_gap", 64'(obs_c[20] - obs_c[19]), 64'd2);
    check_stream("contend");

    // Non-preemption, legacy gate closing mid-frame.
    sched_gate  = 1'b0;
    legacy_gate = 1'b1;
    leg_popped  = 0;
    gen_frame(1'b1, 40);
    for (int i = 0; i < 100 && leg_popped < 10; i++) step();
    sched_gate  = 1'b1;
    legacy_gate = 1'b0;
    gen_frame(1'b0, 25);
    run_until("nopreempt", 400);
    chk("nopreempt_gap", 64'(obs_c[40] - obs_c[39]), 64'd2);
    check_stream("nopreempt");

    // Oversize and limit boundaries.
    legacy_gate = 1'b0;
    gen_frame(1'b0, 150);
    run_until("over150", 500);
    check_stream("over150");
    gen_frame(1'b0, 100);
    run_until("exact100", 400);
    check_stream("exact100");
    legacy_gate = 1'b1;
    sched_gate  = 1'b0;
    gen_frame(1'b1, 101);
    run_until("over101", 400);
    check_stream("over101");

    // Backpressure with a waiting, gated-off scheduled frame.
    rnd_ready = 1'b1;
    gen_frame(1'b1, 60);
    gen_frame(1'b0, 10);
    for (int i = 0; i < 1000 && (lq.size() > 0 || pred_l || busy); i++) step();
    chk("bp_sched_waiting", 64'(sq.size()), 64'd10);
    sched_gate = 1'b1;
    run_until("bp", 400);
    check_stream("bp");

    // Random single frames with random backpressure.
    legacy_gate = 1'b1;
    for (int k = 0; k < 4; k++) begin
      gen_frame(1'($urandom_range(0, 1)), int'($urandom_range(1, 120)));
      run_until("rnd", 2000);
      check_stream("rnd");
    end
    rnd_ready = 1'b0;

    // Reset mid-frame.
    sched_gate = 1'b0;
    leg_popped = 0;
    gen_frame(1'b1, 60);
    for (int i = 0; i < 200 && leg_popped < 20; i++) step();
    tx_mac_resetn = 1'b0;
    #1;
    chk("rst_mid_outs", {54'd0, m_tvalid, m_tlast, m_tuser, busy, s_sched_tready, s_legacy_tready, m_tdata},
        64'd0);
    chk("rst_mid_cnt", {16'd0, sched_frames, legacy_frames, trunc_frames}, 64'd0);
    sq.delete();
    lq.delete();
    expq.delete();
    obs_b.delete();
    obs_c.delete();
    pred_s = 1'b0;
    pred_l = 1'b0;
    exp_s  = 0;
    exp_l  = 0;
    exp_t  = 0;
    s_sched_tvalid  = 1'b0;
    s_legacy_tvalid = 1'b0;
    repeat (2) @(negedge tx_mac_aclk);
    tx_mac_resetn = 1'b1;
    start_cyc = cyc;
    gen_frame(1'b1, 30);
    run_until("post_rst", 300);
    chk("post_rst_latency", 64'(obs_c[0] - start_cyc), 64'd1);
    check_stream("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
